// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock supervisor releasing sys_rst_n after stable lock
// Optional build macro LOCK_GLITCH_FILTER_EN: in RUN, ignore lock dropouts shorter than GLITCH_CYCLES.
module pll_lock_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 27000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int GLITCH_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       locked,
    output logic [1:0] state_o,
    output logic [7:0] relock_cnt
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_P = max2(max2(max2(SYNC_STAGES, PLL_RST_CYCLES),
                                     max2(LOCK_TIMEOUT, STABLE_CYCLES)), GLITCH_CYCLES);
    localparam int CW = $clog2(MAX_P) + 1;
    localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PLLRST = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STABLE = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    lock_s;
    logic                    lock_lost;
    logic                    timed_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

`ifdef LOCK_GLITCH_FILTER_EN
    localparam logic [CW-1:0] GLITCH_LAST = CW'(GLITCH_CYCLES - 1);
    logic [CW-1:0] glitch_cnt;

    assign lock_lost = (state == ST_RUN) && !lock_s && (glitch_cnt == GLITCH_LAST);

    // Counts consecutive low samples in RUN; any high sample or leaving RUN clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt <= '0;
        end else if ((state == ST_RUN) && !lock_s && !lock_lost) begin
            glitch_cnt <= glitch_cnt + CW'(1);
        end else begin
            glitch_cnt <= '0;
        end
    end
`else
    assign lock_lost = (state == ST_RUN) && !lock_s;
`endif

    assign timed_out = (state == ST_WAIT) && !lock_s && (cnt == TIMEOUT_LAST);
    assign state_o   = state;

    // Outputs are loaded together with the next state so they change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_PLLRST;
            cnt        <= '0;
            pll_reset  <= 1'b1;
            sys_rst_n  <= 1'b0;
            locked     <= 1'b0;
            relock_cnt <= 8'd0;
        end else if (relock_req || timed_out || lock_lost) begin
            state     <= ST_PLLRST;
            cnt       <= '0;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
            if ((state != ST_PLLRST) && (relock_cnt != 8'hFF)) begin
                relock_cnt <= relock_cnt + 8'd1;
            end
        end else begin
            case (state)
                ST_PLLRST: begin
                    if (cnt == RST_LAST) begin
                        state     <= ST_WAIT;
                        cnt       <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (lock_s) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state <= ST_WAIT;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state     <= ST_RUN;
                        cnt       <= '0;
                        sys_rst_n <= 1'b1;
                        locked    <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end
endmodule
